// File: rtl/rf_multiport.sv
// Two-read / two-write register file with a sequential clear engine.
// Entries are zeroed one per cycle after reset or on request.
module rf_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] reg_addr_read_1,
  input  logic [ADDR_WIDTH-1:0] reg_addr_read_2,
  output logic [DATA_WIDTH-1:0] reg_data_read_1,
  output logic [DATA_WIDTH-1:0] reg_data_read_2,
  input  logic [ADDR_WIDTH-1:0] reg_addr_write_1,
  input  logic [ADDR_WIDTH-1:0] reg_addr_write_2,
  input  logic [DATA_WIDTH-1:0] reg_data_write_1,
  input  logic [DATA_WIDTH-1:0] reg_data_write_2,
  input  logic                  reg_enable_write_1,
  input  logic                  reg_enable_write_2,
  input  logic                  clear_start,
  output logic                  rf_ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   clear_ptr;
  logic [ADDR_WIDTH-1:0]   clear_ptr_nxt;
  logic                    rf_ready_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    we_1;
  logic                    we_2;
  logic                    zero_1;
  logic                    zero_2;

  // Next-state logic: walk the clear pointer, then sit in READY.
  always_comb begin
    state_nxt     = state;
    clear_ptr_nxt = clear_ptr;
    rf_ready_nxt  = rf_ready;
    unique case (state)
      CLEAR: begin
        clear_ptr_nxt = clear_ptr + ADDR_WIDTH'(1);
        if (clear_ptr == '1) begin
          state_nxt    = READY;
          rf_ready_nxt = 1'b1;
        end
      end
      READY: begin
        if (clear_start) begin
          state_nxt     = CLEAR;
          clear_ptr_nxt = '0;
          rf_ready_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt     = CLEAR;
        clear_ptr_nxt = '0;
        rf_ready_nxt  = 1'b0;
      end
    endcase
  end

  // Control registers with synchronous reset restarting the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clear_ptr <= '0;
      rf_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      clear_ptr <= clear_ptr_nxt;
      rf_ready  <= rf_ready_nxt;
    end
  end

  // Effective write enables; entry 0 is read-only when hardwired.
  always_comb begin
    zero_1 = (ZERO_REG != 0) && (reg_addr_write_1 == '0);
    zero_2 = (ZERO_REG != 0) && (reg_addr_write_2 == '0);
    we_1   = !rst && (state == READY) && reg_enable_write_1 && !zero_1;
    we_2   = !rst && (state == READY) && reg_enable_write_2 && !zero_2;
  end

  // Storage: clear engine or user writes; port 2 lands last on a tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clear_ptr] <= '0;
      end
      if (we_1) begin
        mem[reg_addr_write_1] <= reg_data_write_1;
      end
      if (we_2) begin
        mem[reg_addr_write_2] <= reg_data_write_2;
      end
    end
  end

  // Read port 1: stored value, optional forwarding, zero masking.
  always_comb begin
    reg_data_read_1 = mem[reg_addr_read_1];
    if (BYPASS != 0) begin
      if (we_1 && reg_addr_read_1 == reg_addr_write_1) begin
        reg_data_read_1 = reg_data_write_1;
      end
      if (we_2 && reg_addr_read_1 == reg_addr_write_2) begin
        reg_data_read_1 = reg_data_write_2;
      end
    end
    if (state != READY) begin
      reg_data_read_1 = '0;
    end
    if ((ZERO_REG != 0) && reg_addr_read_1 == '0) begin
      reg_data_read_1 = '0;
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    reg_data_read_2 = mem[reg_addr_read_2];
    if (BYPASS != 0) begin
      if (we_1 && reg_addr_read_2 == reg_addr_write_1) begin
        reg_data_read_2 = reg_data_write_1;
      end
      if (we_2 && reg_addr_read_2 == reg_addr_write_2) begin
        reg_data_read_2 = reg_data_write_2;
      end
    end
    if (state != READY) begin
      reg_data_read_2 = '0;
    end
    if ((ZERO_REG != 0) && reg_addr_read_2 == '0) begin
      reg_data_read_2 = '0;
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: one forwarding and one
// non-forwarding instance share all stimulus.
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, wa1, wa2;
  logic [31:0] wd1, wd2;
  logic        we1, we2, clr;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        rdy_b, rdy_n;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  rf_multiport #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst),
    .reg_addr_read_1(ra1), .reg_addr_read_2(ra2),
    .reg_data_read_1(rd1_b), .reg_data_read_2(rd2_b),
    .reg_addr_write_1(wa1), .reg_addr_write_2(wa2),
    .reg_data_write_1(wd1), .reg_data_write_2(wd2),
    .reg_enable_write_1(we1), .reg_enable_write_2(we2),
    .clear_start(clr), .rf_ready(rdy_b)
  );

  rf_multiport #(.BYPASS(0)) u_nob (
    .clk(clk), .rst(rst),
    .reg_addr_read_1(ra1), .reg_addr_read_2(ra2),
    .reg_data_read_1(rd1_n), .reg_data_read_2(rd2_n),
    .reg_addr_write_1(wa1), .reg_addr_write_2(wa2),
    .reg_data_write_1(wd1), .reg_data_write_2(wd2),
    .reg_enable_write_1(we1), .reg_enable_write_2(we2),
    .clear_start(clr), .rf_ready(rdy_n)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until rf_ready rises, bounded to 40.
  task automatic wait_ready(output int cnt);
    cnt = 41;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rdy_b) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    ra1 = '0; ra2 = '0; wa1 = '0; wa2 = '0;
    wd1 = '0; wd2 = '0; we1 = 1'b0; we2 = 1'b0;
    #2;
    step();
    rst = 1'b0;
    #1;
    chk("rst_rdy", {31'd0, rdy_b}, 32'd0);
    chk("rst_rdy_n", {31'd0, rdy_n}, 32'd0);
    wait_ready(n);
    chk("rst_edges", 32'(n), 32'd32);
    chk("rst_rdy_n1", {31'd0, rdy_n}, 32'd1);

    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      chk("clr_rd1", rd1_b, 32'd0);
      chk("clr_rd2", rd2_n, 32'd0);
    end

    // Port 1 write with same-cycle read.
    wa1 = 5'd5; wd1 = 32'hDEADBEEF; we1 = 1'b1; ra1 = 5'd5;
    #1;
    chk("byp_same", rd1_b, 32'hDEADBEEF);
    chk("nob_same", rd1_n, 32'd0);
    step();
    we1 = 1'b0;
    #1;
    chk("byp_next", rd1_b, 32'hDEADBEEF);
    chk("nob_next", rd1_n, 32'hDEADBEEF);

    // Same-address dual write: port 2 wins.
    wa1 = 5'd7; wd1 = 32'h11; we1 = 1'b1;
    wa2 = 5'd7; wd2 = 32'h22; we2 = 1'b1; ra2 = 5'd7;
    #1;
    chk("tie_byp", rd2_b, 32'h22);
    step();
    we1 = 1'b0; we2 = 1'b0;
    #1;
    chk("tie_b", rd2_b, 32'h22);
    chk("tie_n", rd2_n, 32'h22);

    // Writes to entry 0 are dropped, no forwarding either.
    wa1 = 5'd0; wd1 = 32'hFFFF; we1 = 1'b1; ra1 = 5'd0;
    #1;
    chk("z_byp", rd1_b, 32'd0);
    step();
    we1 = 1'b0;
    #1;
    chk("z_b", rd1_b, 32'd0);
    chk("z_n", rd1_n, 32'd0);

    // Distinct addresses write together.
    wa1 = 5'd9; wd1 = 32'h99; we1 = 1'b1;
    wa2 = 5'd10; wd2 = 32'hAA; we2 = 1'b1;
    step();
    we1 = 1'b0; we2 = 1'b0;
    ra1 = 5'd9; ra2 = 5'd10;
    #1;
    chk("dual_1", rd1_n, 32'h99);
    chk("dual_2", rd2_n, 32'hAA);
    ra1 = 5'd5;
    #1;
    chk("hold_5", rd1_n, 32'hDEADBEEF);

    // Old value visible without forwarding.
    wa2 = 5'd3; wd2 = 32'h33; we2 = 1'b1;
    step();
    wd2 = 32'hA5; ra1 = 5'd3;
    #1;
    chk("nob_old", rd1_n, 32'h33);
    chk("byp_new", rd1_b, 32'hA5);
    step();
    we2 = 1'b0;
    #1;
    chk("nob_a5", rd1_n, 32'hA5);
    chk("byp_a5", rd1_b, 32'hA5);

    // Clear request: writes ignored, reads zero, no restart.
    wa1 = 5'd31; wd1 = 32'h1234; we1 = 1'b1;
    step();
    we1 = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_rdy0", {31'd0, rdy_b}, 32'd0);
    wa1 = 5'd31; wd1 = 32'hBEEF; we1 = 1'b1;
    wa2 = 5'd12; wd2 = 32'h5A; we2 = 1'b1;
    ra1 = 5'd31; ra2 = 5'd12;
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      if (rd1_b != 0 || rd2_b != 0 || rd1_n != 0)
        chk("clr_rd_zero", rd1_b | rd2_b | rd1_n, 32'd0);
      clr = (i == 10);
      step();
      if (rdy_b) begin
        n = i;
        break;
      end
    end
    clr = 1'b0; we1 = 1'b0; we2 = 1'b0;
    #1;
    chk("clr_edges", 32'(n), 32'd32);
    chk("clr_31", rd1_b, 32'd0);
    chk("clr_12", rd2_n, 32'd0);
    ra1 = 5'd5;
    #1;
    chk("clr_5", rd1_n, 32'd0);

    // Reset mid-clear restarts the sequence.
    wa1 = 5'd20; wd1 = 32'h77; we1 = 1'b1;
    step();
    we1 = 1'b0; ra1 = 5'd20;
    #1;
    chk("pre_20", rd1_n, 32'h77);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rdy0", {31'd0, rdy_b}, 32'd0);
    wait_ready(n);
    chk("mid_edges", 32'(n), 32'd32);
    chk("mid_20", rd1_n, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
